// File: rtl/uart_pkg.sv
// Shared constants, types and helpers for the UART command decoder.
package uart_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_U  = 8'h55;
  localparam logic [7:0] ASCII_N  = 8'h4E;
  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_T  = 8'h54;
  localparam logic [7:0] ASCII_P  = 8'h50;
  localparam logic [7:0] ASCII_C  = 8'h43;
  localparam logic [7:0] ASCII_L  = 8'h4C;

  localparam logic [23:0] CMD_RUN = {ASCII_R, ASCII_U, ASCII_N};
  localparam logic [23:0] CMD_STP = {ASCII_S, ASCII_T, ASCII_P};
  localparam logic [23:0] CMD_CLR = {ASCII_C, ASCII_L, ASCII_R};
  localparam logic [23:0] CMD_SNS = {ASCII_S, ASCII_N, ASCII_S};

  typedef enum logic [1:0] {
    CODE_RUN = 2'd0,
    CODE_STP = 2'd1,
    CODE_CLR = 2'd2,
    CODE_SNS = 2'd3
  } cmd_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POPW = 2'd1,
    ST_EVAL = 2'd2
  } state_e;

  function automatic logic [7:0] fold_upper(input logic [7:0] b);
    if ((b >= 8'h61) && (b <= 8'h7A)) begin
      fold_upper = b - 8'h20;
    end else begin
      fold_upper = b;
    end
  endfunction

endpackage

// File: rtl/cmd_match.sv
// Combinational lookup of a 3-character sequence in the command table.
module cmd_match
  import uart_pkg::*;
(
  input  logic [23:0] seq_i,
  output logic        hit_o,
  output cmd_code_e   code_o
);

  // Table lookup; default covers every unmatched sequence
  always_comb begin
    hit_o  = 1'b1;
    code_o = CODE_RUN;
    case (seq_i)
      CMD_RUN: code_o = CODE_RUN;
      CMD_STP: code_o = CODE_STP;
      CMD_CLR: code_o = CODE_CLR;
      CMD_SNS: code_o = CODE_SNS;
      default: hit_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Decodes 3-character ASCII commands from the UART RX FIFO into one-cycle
// control pulses, with inter-character timeout and CR/LF resynchronisation.
module uart_cmd_decoder
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 20_000_000,
  parameter bit          CASE_FOLD      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       pop_rx,
  output logic       cmd_valid,
  output logic [1:0] cmd_code,
  output logic       cmd_run,
  output logic       cmd_stop,
  output logic       cmd_clear,
  output logic       cmd_sensor,
  output logic [7:0] err_cnt
);

  state_e      state_q, state_d;
  logic        rdy_q;
  logic [7:0]  byte_q, byte_d;
  logic [7:0]  c1_q, c1_d;
  logic [7:0]  c2_q, c2_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] gap_q, gap_d;
  logic        cmd_valid_q, cmd_valid_d;
  cmd_code_e   cmd_code_q, cmd_code_d;
  logic [3:0]  pulse_q, pulse_d;
  logic [7:0]  err_q, err_d;

  logic        pop_s;
  logic        hit_s;
  cmd_code_e   match_code_s;
  logic        is_eol_s;

  // rdy_q keeps pop_rx low while in reset and for the first cycle after it
  assign pop_s    = rdy_q && (state_q == ST_IDLE) && rx_valid;
  assign is_eol_s = (byte_q == ASCII_CR) || (byte_q == ASCII_LF);

  cmd_match u_cmd_match (
    .seq_i  ({c1_q, c2_q, byte_q}),
    .hit_o  (hit_s),
    .code_o (match_code_s)
  );

  // Next-state, buffer, timeout and output decode
  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    c1_d        = c1_q;
    c2_d        = c2_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    cmd_valid_d = 1'b0;
    cmd_code_d  = cmd_code_q;
    pulse_d     = 4'b0000;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          byte_d  = CASE_FOLD ? fold_upper(rx_data) : rx_data;
          state_d = ST_POPW;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_POPW: state_d = ST_EVAL;
      ST_EVAL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_q == ST_EVAL) begin
      gap_d = 32'd0;
      if (is_eol_s) begin
        cnt_d = 2'd0;
        c1_d  = 8'h00;
        c2_d  = 8'h00;
      end else if (cnt_q == 2'd2) begin
        // Third byte completes the sequence: match or count an error
        if (hit_s) begin
          cmd_valid_d = 1'b1;
          cmd_code_d  = match_code_s;
          pulse_d     = 4'b0001 << match_code_s;
        end else if (err_q != 8'hFF) begin
          err_d = err_q + 8'd1;
        end else begin
          err_d = err_q;
        end
        cnt_d = 2'd0;
        c1_d  = 8'h00;
        c2_d  = 8'h00;
      end else begin
        c1_d  = c2_q;
        c2_d  = byte_q;
        cnt_d = cnt_q + 2'd1;
      end
    end else if (pop_s || (cnt_q == 2'd0) || (TIMEOUT_CYCLES == 0)) begin
      gap_d = 32'd0;
    end else if (gap_q == (TIMEOUT_CYCLES - 32'd1)) begin
      gap_d = 32'd0;
      cnt_d = 2'd0;
      c1_d  = 8'h00;
      c2_d  = 8'h00;
    end else begin
      gap_d = gap_q + 32'd1;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rdy_q       <= 1'b0;
      byte_q      <= 8'h00;
      c1_q        <= 8'h00;
      c2_q        <= 8'h00;
      cnt_q       <= 2'd0;
      gap_q       <= 32'd0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= CODE_RUN;
      pulse_q     <= 4'b0000;
      err_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      rdy_q       <= 1'b1;
      byte_q      <= byte_d;
      c1_q        <= c1_d;
      c2_q        <= c2_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      pulse_q     <= pulse_d;
      err_q       <= err_d;
    end
  end

  assign pop_rx     = pop_s;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = cmd_code_q;
  assign cmd_run    = pulse_q[0];
  assign cmd_stop   = pulse_q[1];
  assign cmd_clear  = pulse_q[2];
  assign cmd_sensor = pulse_q[3];
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench: stimulus queues expected commands, a monitor checks every pulse.
module tb_uart_cmd_decoder;

  typedef struct packed {
    logic [1:0] code;
    logic [7:0] err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid0, rx_valid1;
  logic [7:0] rx_data0, rx_data1;
  logic       pop0, pop1;
  logic       cv0, cv1;
  logic [1:0] code0, code1;
  logic       run0, stop0, clr0, sns0;
  logic       run1, stop1, clr1, sns1;
  logic [7:0] err0, err1;

  logic [7:0] fifo0[$];
  logic [7:0] fifo1[$];
  exp_t       exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_pop = -100;
  int b2b = 0;
  int b2b_pops = 0;

  always #5 clk = ~clk;

  uart_cmd_decoder #(.TIMEOUT_CYCLES(1000), .CASE_FOLD(1'b1)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid0), .rx_data(rx_data0), .pop_rx(pop0),
    .cmd_valid(cv0), .cmd_code(code0), .cmd_run(run0), .cmd_stop(stop0),
    .cmd_clear(clr0), .cmd_sensor(sns0), .err_cnt(err0)
  );

  uart_cmd_decoder #(.TIMEOUT_CYCLES(1000), .CASE_FOLD(1'b0)) dut_nf (
    .clk(clk), .rst(rst), .rx_valid(rx_valid1), .rx_data(rx_data1), .pop_rx(pop1),
    .cmd_valid(cv1), .cmd_code(code1), .cmd_run(run1), .cmd_stop(stop1),
    .cmd_clear(clr1), .cmd_sensor(sns1), .err_cnt(err1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Show-ahead FIFO models
  always @(posedge clk) begin
    if (pop0 === 1'b1 && fifo0.size() != 0) void'(fifo0.pop_front());
    if (pop1 === 1'b1 && fifo1.size() != 0) void'(fifo1.pop_front());
    #1;
    rx_valid0 = (fifo0.size() != 0);
    rx_data0  = rx_valid0 ? fifo0[0] : 8'h00;
    rx_valid1 = (fifo1.size() != 0);
    rx_data1  = rx_valid1 ? fifo1[0] : 8'h00;
  end

  // Monitor for the case-folding instance
  always @(negedge clk) begin
    exp_t e;
    if (cv0 === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_cmd: actual code=%0d expected no command", code0);
      end else begin
        e = exp_q.pop_front();
        chk("cmd_code", {30'd0, code0}, {30'd0, e.code});
        chk("cmd_onehot", {28'd0, sns0, clr0, stop0, run0}, {28'd0, 4'b0001 << e.code});
        chk("err_at_cmd", {24'd0, err0}, {24'd0, e.err});
        chk("latency", cyc - last_pop, 3);
      end
    end else if ({sns0, clr0, stop0, run0} !== 4'b0000) begin
      total++;
      bad++;
      $display("FAIL pulse_without_valid: actual=%b expected=0000", {sns0, clr0, stop0, run0});
    end
    if (pop0 === 1'b1) begin
      chk("pop_needs_valid", {31'd0, rx_valid0}, 32'd1);
      if (cyc - last_pop < 3) begin
        total++;
        bad++;
        $display("FAIL pop_spacing: actual=%0d expected>=3", cyc - last_pop);
      end
      if (b2b != 0 && b2b_pops > 0) chk("b2b_spacing", cyc - last_pop, 3);
      if (b2b != 0) b2b_pops <= b2b_pops + 1;
      last_pop <= cyc;
    end
  end

  // Monitor for the exact-match instance: it never sees a valid command
  always @(negedge clk) begin
    if (cv1 === 1'b1) begin
      total++;
      bad++;
      $display("FAIL nofold_unexpected_cmd: actual code=%0d expected no command", code1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_empty();
    int k = 0;
    while ((fifo0.size() != 0 || fifo1.size() != 0) && k < 5000) begin
      @(posedge clk);
      k++;
    end
    if (k >= 5000) begin
      total++;
      bad++;
      $display("FAIL fifo_drain_timeout: actual remaining=%0d expected 0", fifo0.size() + fifo1.size());
    end
  endtask

  task automatic send(input int which, input logic [7:0] b, input int gap);
    @(posedge clk);
    if (which == 0) fifo0.push_back(b);
    else fifo1.push_back(b);
    wait_empty();
    tick(gap);
  endtask

  task automatic send_str(input int which, input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send(which, s[i], gap);
  endtask

  initial begin
    rst = 1'b0;
    rx_valid0 = 1'b0; rx_data0 = 8'h00;
    rx_valid1 = 1'b0; rx_data1 = 8'h00;
    tick(3);
    @(negedge clk);
    chk("rst_cmd_valid", {31'd0, cv0}, 32'd0);
    chk("rst_cmd_code", {30'd0, code0}, 32'd0);
    chk("rst_err_cnt", {24'd0, err0}, 32'd0);
    rst = 1'b1;
    tick(3);

    // RUN with gaps
    exp_q.push_back({2'd0, 8'd0});
    send_str(0, "RUN", 20);
    tick(8);
    @(negedge clk);
    chk("err_after_run", {24'd0, err0}, 32'd0);

    // lowercase: folded on one instance, mismatch on the other
    exp_q.push_back({2'd1, 8'd0});
    send_str(0, "stp", 20);
    send_str(1, "stp", 20);
    tick(8);
    @(negedge clk);
    chk("err_nofold", {24'd0, err1}, 32'd1);
    chk("err_fold", {24'd0, err0}, 32'd0);

    // Timeout discards "SN"; only the second SNS fires
    send_str(0, "SN", 20);
    tick(1100);
    exp_q.push_back({2'd3, 8'd0});
    send_str(0, "SNS", 20);
    tick(8);
    @(negedge clk);
    chk("err_after_timeout", {24'd0, err0}, 32'd0);

    // Gap just under the timeout keeps the partial buffer
    exp_q.push_back({2'd3, 8'd0});
    send_str(0, "SN", 20);
    tick(880);
    send_str(0, "S", 20);
    tick(8);

    // Mismatch then a valid command
    send_str(0, "RUX", 20);
    tick(8);
    @(negedge clk);
    chk("err_after_rux", {24'd0, err0}, 32'd1);
    exp_q.push_back({2'd2, 8'd1});
    send_str(0, "CLR", 20);
    tick(8);

    // Preloaded FIFO: pops every 3 cycles, LF resyncs
    b2b = 1;
    exp_q.push_back({2'd3, 8'd1});
    @(posedge clk);
    fifo0.push_back(8'h52); fifo0.push_back(8'h55); fifo0.push_back(8'h0A);
    fifo0.push_back(8'h53); fifo0.push_back(8'h4E); fifo0.push_back(8'h53);
    wait_empty();
    tick(8);
    b2b = 0;
    @(negedge clk);
    chk("b2b_pops", b2b_pops, 6);

    // Reset mid-command, with a byte waiting during reset
    send_str(0, "RU", 20);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    fifo0.push_back(8'h4E);
    tick(3);
    @(negedge clk);
    chk("inrst_pop", {31'd0, pop0}, 32'd0);
    chk("inrst_cmd_valid", {31'd0, cv0}, 32'd0);
    chk("inrst_cmd_code", {30'd0, code0}, 32'd0);
    chk("inrst_err_cnt", {24'd0, err0}, 32'd0);
    rst = 1'b1;
    wait_empty();
    tick(8);
    @(negedge clk);
    chk("err_after_reset_n", {24'd0, err0}, 32'd0);
    send(0, 8'h0A, 20);

    // Non-printable byte counts toward a mismatch
    send(0, 8'h52, 5);
    send(0, 8'h01, 5);
    send(0, 8'h4E, 5);
    tick(8);
    @(negedge clk);
    chk("err_nonprint", {24'd0, err0}, 32'd1);

    // Error counter saturates at 255
    @(posedge clk);
    for (int i = 0; i < 255; i++) begin
      fifo0.push_back(8'h58); fifo0.push_back(8'h59); fifo0.push_back(8'h5A);
    end
    wait_empty();
    tick(8);
    @(negedge clk);
    chk("err_saturate", {24'd0, err0}, 32'd255);

    chk("leftover_expected", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Consumes received bytes from UART_CTRL's RX FIFO side (rx_valid / rx_data / pop_rx) and decodes 3-character ASCII commands into single-cycle control pulses for the sensor datapath.
- Sits directly downstream of UART_CTRL and upstream of the sensor controller.
- Commands: "RUN", "STP", "CLR", "SNS".
- Includes inter-character timeout, optional case folding and CR/LF resynchronisation.

Parameters:
- TIMEOUT_CYCLES, 20_000_000, max clk cycles between consecutive bytes of one command (200 ms at 100 MHz); 0 disables the timeout.
- CASE_FOLD, 1, 1 = ASCII 'a'..'z' folded to 'A'..'Z' before matching; 0 = exact match.

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  asynchronous, active-low reset
- rx_valid  input  1  RX FIFO not empty (from UART_CTRL)
- rx_data  input  8  RX FIFO head byte, valid while rx_valid=1 (show-ahead)
- pop_rx  output  1  one-cycle pop strobe to RX FIFO
- cmd_valid  output  1  one-cycle pulse: command recognised
- cmd_code  output  2  0=RUN, 1=STP, 2=CLR, 3=SNS; held until next cmd_valid
- cmd_run, cmd_stop, cmd_clear, cmd_sensor  output  1 each  one-cycle decoded pulses, coincident with cmd_valid
- err_cnt  output  8  saturating count of unmatched 3-char sequences

Behaviour:
- Reset (rst=0, async): all outputs 0; state IDLE; char buffer and counters cleared; cmd_code=0.
- FSM states and transitions:
  - IDLE: if rx_valid, latch rx_data (folded if CASE_FOLD), assert pop_rx for exactly one cycle, go to POPW.
  - POPW: one wait cycle so the FIFO empty flag updates; no pop is allowed here; go to EVAL.
  - EVAL: process the latched byte, then go to IDLE.
- Throughput: at most one byte per 3 cycles; no back-to-back pop_rx, ever.
- EVAL rules:
  - If byte is CR (0x0D) or LF (0x0A): clear buffer (count=0); no error.
  - Otherwise shift byte into 3-byte buffer c0<-c1<-c2<-byte and increment count (saturates at 3).
  - When count reaches 3:
    - If {c0,c1,c2} matches a table entry: pulse cmd_valid plus the matching cmd_* in the cycle after EVAL (registered), update cmd_code, clear buffer.
    - If no match: err_cnt+1 (saturate at 255), clear buffer.
- Latency: pop_rx cycle of the final command byte to cmd_valid = 3 clk cycles.
- Timeout:
  - Gap counter resets on each pop_rx and runs while count is 1 or 2.
  - When it reaches TIMEOUT_CYCLES: clear buffer silently (no error).
  - Not running when count=0.
  - If timeout expiry and EVAL fall in the same cycle, EVAL wins; the counter restarts.
- Bytes outside 0x20..0x7E other than CR/LF are treated as ordinary bytes, i.e. they count toward a mismatch.
- The block never pops while rx_valid=0. If rx_valid drops during POPW/EVAL, the latched byte is still processed.
- Reset mid-command discards the partial buffer; no pulse is generated.

Decomposition:
- Shared package uart_pkg:
  - ASCII constants (CR, LF, 'R','U','N','S','T','P','C','L').
  - 24-bit command literals CMD_RUN/STP/CLR/SNS.
  - 2-bit cmd_code enum.
  - FSM state encoding.
- One natural sub-module: cmd_match, a combinational 24-bit compare of the buffer against the table, returning hit and code.
- The timeout counter stays inline.

Test Plan:
- Reset released, then serial 'R','U','N' through UART_CTRL at 9600 baud with 2 ms gaps -> cmd_valid and cmd_run pulse once, cmd_code=0, err_cnt=0.
- "stp" lowercase with CASE_FOLD=1 -> cmd_stop pulse, cmd_code=1. Same stimulus with CASE_FOLD=0 -> no pulse, err_cnt=1.
- "RUX" then "CLR" -> err_cnt=1 after 3rd byte, then cmd_clear pulse, cmd_code=2.
- TIMEOUT_CYCLES=1000 in sim; send 'S','N', idle more than 1000 cycles, then 'S','N','S' -> only one cmd_sensor pulse (after 2nd "SNS"), err_cnt=0.
- 'R','U',LF,'S','N','S' fed from a preloaded FIFO model with rx_valid held high -> pop_rx pulses separated by exactly 3 cycles; cmd_sensor only; 6 pops total.
- Assert rst=0 after 'R','U'; release and send 'N' -> no command pulse; outputs 0 during reset.
